// File: rtl/programmable_sequence_generator.sv
// programmable_sequence_generator
//
// Serializes a latched WIDTH-bit pattern MSB-first over a valid/ready serial
// link, repeating it `reps` times per burst. Transmit-side counterpart to the
// programmable sequence detector; `dout` feeds the detector's `din`.
//
// Optional feature (compile-time macro):
//   SEQGEN_GAP_EN - insert one cycle with dout_valid=0 between consecutive
//                   repetitions (framing gap). Undefined: back-to-back.
//
// Parameters:
//   WIDTH  pattern length in bits (2..16)
//   CNT_W  width of the repeat-count input
//
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   begin a burst (sampled only in IDLE)
//   init        in   pattern, latched on an accepted start
//   reps        in   repetition count, latched on an accepted start
//   dout_ready  in   sink accepts the current bit at this edge
//   dout        out  serial bit, MSB first; 0 when dout_valid=0
//   dout_valid  out  dout holds a bit to transfer
//   busy        out  burst in progress
//   done        out  one-cycle pulse after the last bit of a burst
//
// All outputs are registered.

module programmable_sequence_generator #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] init,
    input  logic [CNT_W-1:0] reps,
    input  logic             dout_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

`ifdef SEQGEN_GAP_EN
    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e           state, state_next;
    logic [WIDTH-1:0] pat, pat_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] rep_left, rep_left_next;
    logic             dout_next;
    logic             dout_valid_next;
    logic             busy_next;
    logic             done_next;

    logic [IDX_W-1:0] idx_dec;

    assign idx_dec = idx - IDX_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            pat        <= '0;
            idx        <= '0;
            rep_left   <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            pat        <= pat_next;
            idx        <= idx_next;
            rep_left   <= rep_left_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Outputs are computed one cycle ahead so they can be registered while
    // still matching the state they describe.
    always_comb begin
        state_next      = state;
        pat_next        = pat;
        idx_next        = idx;
        rep_left_next   = rep_left;
        dout_next       = dout;
        dout_valid_next = dout_valid;
        busy_next       = busy;
        done_next       = 1'b0;

        unique case (state)
            StIdle: begin
                dout_next       = 1'b0;
                dout_valid_next = 1'b0;
                busy_next       = 1'b0;
                if (start && (reps != '0)) begin
                    state_next      = StShift;
                    pat_next        = init;
                    rep_left_next   = reps;
                    idx_next        = IDX_MAX;
                    dout_next       = init[WIDTH-1];
                    dout_valid_next = 1'b1;
                    busy_next       = 1'b1;
                end
            end

            StShift: begin
                // No transfer: everything holds, so the bit is neither skipped
                // nor duplicated under backpressure.
                if (dout_ready) begin
                    if (idx != '0) begin
                        idx_next  = idx_dec;
                        dout_next = pat[idx_dec];
                    end else if (rep_left > CNT_W'(1)) begin
                        rep_left_next = rep_left - CNT_W'(1);
                        idx_next      = IDX_MAX;
`ifdef SEQGEN_GAP_EN
                        state_next      = StGap;
                        dout_next       = 1'b0;
                        dout_valid_next = 1'b0;
`else
                        dout_next = pat[WIDTH-1];
`endif
                    end else begin
                        state_next      = StIdle;
                        dout_next       = 1'b0;
                        dout_valid_next = 1'b0;
                        busy_next       = 1'b0;
                        done_next       = 1'b1;
                    end
                end
            end

`ifdef SEQGEN_GAP_EN
            // Single framing cycle; dout_ready is not consulted.
            StGap: begin
                state_next      = StShift;
                dout_next       = pat[WIDTH-1];
                dout_valid_next = 1'b1;
                busy_next       = 1'b1;
            end
`endif

            default: begin
                state_next      = StIdle;
                dout_next       = 1'b0;
                dout_valid_next = 1'b0;
                busy_next       = 1'b0;
            end
        endcase
    end

endmodule
